// File: rtl/ln_engine_arbiter.sv
// rtl/ln_engine_arbiter.sv - round-robin arbiter sharing one ln(1+x) engine among NREQ requesters
// Owns the engine start line; one operation in flight, watchdog-bounded.
module ln_engine_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 4096
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NREQ-1:0]      req,
  input  logic [32*NREQ-1:0]   req_x,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [31:0]          rsp_ln,
  output logic                 rsp_err,
  output logic                 rsp_timeout,
  output logic [15:0]          rsp_cycles,
  output logic [31:0]          eng_x,
  output logic                 eng_start,
  input  logic [1:0]           eng_status,
  input  logic [31:0]          eng_ln,
  output logic                 busy,
  output logic [2:0]           grant_id
);

  typedef enum logic [2:0] {S_IDLE, S_START, S_WAIT1, S_WAIT2, S_RESP, S_GAP} state_t;

  localparam logic [15:0] TIMEOUT_C = 16'(TIMEOUT);

  state_t            state_q, state_d;
  logic [NREQ-1:0]   rsp_valid_q, rsp_valid_d;
  logic [31:0]       rsp_ln_q, rsp_ln_d;
  logic              rsp_err_q, rsp_err_d;
  logic              rsp_timeout_q, rsp_timeout_d;
  logic [15:0]       rsp_cycles_q, rsp_cycles_d;
  logic [31:0]       eng_x_q, eng_x_d;
  logic              eng_start_q, eng_start_d;
  logic              busy_q, busy_d;
  logic [2:0]        grant_id_q, grant_id_d;
  logic [2:0]        rr_q, rr_d;
  logic [15:0]       cnt_q, cnt_d;

  logic [15:0]       cnt_inc;
  logic [2:0]        pick;
  logic              pick_ok;
  logic [3:0]        scan;
  logic [31:0]       pick_x;
  logic [NREQ-1:0]   grant_onehot;
  logic              expire;

  // Scan from rr upward; iterating offsets high-to-low lets the nearest requester win.
  always_comb begin
    pick    = '0;
    pick_ok = 1'b0;
    scan    = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      scan = {1'b0, rr_q} + 4'(k);
      if (scan >= 4'(NREQ)) begin
        scan = scan - 4'(NREQ);
      end
      for (int i = 0; i < NREQ; i++) begin
        if (scan[2:0] == 3'(i) && req[i]) begin
          pick    = 3'(i);
          pick_ok = 1'b1;
        end
      end
    end
  end

  always_comb begin
    pick_x       = '0;
    grant_onehot = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick == 3'(i)) begin
        pick_x = req_x[32*i +: 32];
      end
      grant_onehot[i] = (grant_id_q == 3'(i));
    end
  end

  assign cnt_inc = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

  always_comb begin
    state_d       = state_q;
    rsp_valid_d   = '0;
    rsp_ln_d      = rsp_ln_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;
    rsp_cycles_d  = rsp_cycles_q;
    eng_x_d       = eng_x_q;
    eng_start_d   = eng_start_q;
    grant_id_d    = grant_id_q;
    rr_d          = rr_q;
    cnt_d         = cnt_q;
    expire        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (eng_status[1] && pick_ok) begin
          grant_id_d = pick;
          eng_x_d    = pick_x;
          cnt_d      = '0;
          state_d    = S_START;
        end
      end
      S_START: begin
        eng_start_d = 1'b1;
        state_d     = S_WAIT1;
      end
      S_WAIT1: begin
        cnt_d = cnt_inc;
        if (cnt_inc >= TIMEOUT_C) begin
          expire = 1'b1;
        end else if (!eng_status[1]) begin
          eng_start_d = 1'b0;
          state_d     = S_WAIT2;
        end
      end
      S_WAIT2: begin
        cnt_d = cnt_inc;
        if (eng_status[1]) begin
          rsp_ln_d      = eng_ln;
          rsp_err_d     = eng_status[0];
          rsp_timeout_d = 1'b0;
          rsp_cycles_d  = cnt_inc;
          rsp_valid_d   = grant_onehot;
          state_d       = S_RESP;
        end else if (cnt_inc >= TIMEOUT_C) begin
          expire = 1'b1;
        end
      end
      S_RESP: begin
        rr_d    = (grant_id_q == 3'(NREQ - 1)) ? 3'd0 : grant_id_q + 3'd1;
        state_d = S_GAP;
      end
      S_GAP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abandon the engine; a late finish is drained by IDLE waiting for done.
    if (expire) begin
      eng_start_d   = 1'b0;
      rsp_ln_d      = '0;
      rsp_err_d     = 1'b1;
      rsp_timeout_d = 1'b1;
      rsp_cycles_d  = TIMEOUT_C;
      rsp_valid_d   = grant_onehot;
      state_d       = S_RESP;
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      rsp_valid_q   <= '0;
      rsp_ln_q      <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
      rsp_cycles_q  <= '0;
      eng_x_q       <= '0;
      eng_start_q   <= 1'b0;
      busy_q        <= 1'b0;
      grant_id_q    <= '0;
      rr_q          <= '0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_ln_q      <= rsp_ln_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
      rsp_cycles_q  <= rsp_cycles_d;
      eng_x_q       <= eng_x_d;
      eng_start_q   <= eng_start_d;
      busy_q        <= busy_d;
      grant_id_q    <= grant_id_d;
      rr_q          <= rr_d;
      cnt_q         <= cnt_d;
    end
  end

  assign rsp_valid   = rsp_valid_q;
  assign rsp_ln      = rsp_ln_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_timeout_q;
  assign rsp_cycles  = rsp_cycles_q;
  assign eng_x       = eng_x_q;
  assign eng_start   = eng_start_q;
  assign busy        = busy_q;
  assign grant_id    = grant_id_q;

endmodule

// File: tb/tb_ln_engine_arbiter.sv
// tb/tb_ln_engine_arbiter.sv - directed self-checking bench for ln_engine_arbiter
// Behavioural engine: accepts start while done=1, finishes LAT edges later.
module tb_ln_engine_arbiter;

  localparam int NREQ = 4;
  localparam int LAT  = 20;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [3:0]      req;
  logic [127:0]    req_x;
  logic [3:0]      rsp_valid;
  logic [31:0]     rsp_ln;
  logic            rsp_err;
  logic            rsp_timeout;
  logic [15:0]     rsp_cycles;
  logic [31:0]     eng_x;
  logic            eng_start;
  logic [1:0]      eng_status;
  logic [31:0]     eng_ln;
  logic            busy;
  logic [2:0]      grant_id;

  int n_cmp = 0;
  int n_bad = 0;

  logic        hang;
  logic        force_busy;
  logic        eng_done_r = 1'b1;
  logic        eng_err_r = 1'b0;
  logic [31:0] eng_ln_r = '0;
  int          eng_cnt = 0;

  logic [31:0] exp_ln [4];
  logic [3:0]  oh;
  int          exp_g;

  ln_engine_arbiter #(.NREQ(NREQ), .TIMEOUT(64)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .req_x(req_x),
    .rsp_valid(rsp_valid), .rsp_ln(rsp_ln), .rsp_err(rsp_err),
    .rsp_timeout(rsp_timeout), .rsp_cycles(rsp_cycles),
    .eng_x(eng_x), .eng_start(eng_start), .eng_status(eng_status),
    .eng_ln(eng_ln), .busy(busy), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  function automatic logic [32:0] eng_lookup(input logic [31:0] x);
    case (x)
      32'h3f800000: return {1'b0, 32'h3f488889};
      32'hbf99999a: return {1'b1, 32'hc060c5a8};
      32'h3e4ccccd: return {1'b0, 32'h3e3ab4e4};
      32'h3ecccccd: return {1'b0, 32'h3eac88d1};
      32'h3f19999a: return {1'b0, 32'h3ef3471f};
      32'h3f4ccccd: return {1'b0, 32'h3f1d222c};
      32'h00000000: return {1'b0, 32'h00000000};
      default:      return {1'b1, 32'h7fc00000};
    endcase
  endfunction

  assign eng_status = {eng_done_r & ~force_busy, eng_err_r};
  assign eng_ln     = eng_ln_r;

  always @(posedge clk) begin
    if (eng_done_r && !force_busy && eng_start) begin
      eng_done_r <= 1'b0;
      eng_cnt    <= LAT;
      {eng_err_r, eng_ln_r} <= eng_lookup(eng_x);
    end else if (!eng_done_r && !hang) begin
      if (eng_cnt <= 1) eng_done_r <= 1'b1;
      eng_cnt <= eng_cnt - 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_rsp(input int budget);
    int waited;
    waited = 0;
    while (rsp_valid == '0 && waited < budget) begin
      @(negedge clk);
      waited++;
    end
    n_cmp++;
    assert (rsp_valid !== '0) else begin
      n_bad++;
      $error("FAIL wait_rsp observed=no_strobe expected=strobe_within_%0d", budget);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_rsp_valid"},   32'(rsp_valid), 32'd0);
    chk({tag, "_rsp_ln"},      rsp_ln, 32'd0);
    chk({tag, "_rsp_err"},     32'(rsp_err), 32'd0);
    chk({tag, "_rsp_timeout"}, 32'(rsp_timeout), 32'd0);
    chk({tag, "_rsp_cycles"},  32'(rsp_cycles), 32'd0);
    chk({tag, "_eng_x"},       eng_x, 32'd0);
    chk({tag, "_eng_start"},   32'(eng_start), 32'd0);
    chk({tag, "_busy"},        32'(busy), 32'd0);
    chk({tag, "_grant_id"},    32'(grant_id), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_watchdog observed=still_running expected=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    exp_ln[0] = 32'h3e3ab4e4;
    exp_ln[1] = 32'h3eac88d1;
    exp_ln[2] = 32'h3ef3471f;
    exp_ln[3] = 32'h3f1d222c;
    reset_n    = 1'b0;
    req        = '0;
    req_x      = '0;
    hang       = 1'b0;
    force_busy = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    reset_n = 1'b1;

    // Single request, checking the start handshake edge by edge.
    req_x[31:0] = 32'h3f800000;
    req[0]      = 1'b1;
    @(negedge clk);
    chk("single_busy", 32'(busy), 32'd1);
    chk("single_eng_x", eng_x, 32'h3f800000);
    chk("single_start_e0", 32'(eng_start), 32'd0);
    @(negedge clk);
    chk("single_start_e1", 32'(eng_start), 32'd1);
    @(negedge clk);
    chk("single_start_e2", 32'(eng_start), 32'd1);
    @(negedge clk);
    chk("single_start_fall", 32'(eng_start), 32'd0);
    wait_rsp(100);
    chk("single_valid", 32'(rsp_valid), 32'h1);
    chk("single_ln", rsp_ln, 32'h3f488889);
    chk("single_err", 32'(rsp_err), 32'd0);
    chk("single_to", 32'(rsp_timeout), 32'd0);
    chk("single_cycles", 32'(rsp_cycles), 32'd22);
    chk("single_grant", 32'(grant_id), 32'd0);
    req[0] = 1'b0;
    @(negedge clk);
    chk("single_strobe_len", 32'(rsp_valid), 32'd0);
    chk("single_gap_busy", 32'(busy), 32'd1);
    @(negedge clk);
    chk("single_idle_busy", 32'(busy), 32'd0);
    chk("single_ln_hold", rsp_ln, 32'h3f488889);

    // Error passthrough from requester 2.
    req_x[95:64] = 32'hbf99999a;
    req[2]       = 1'b1;
    wait_rsp(100);
    chk("err_valid", 32'(rsp_valid), 32'h4);
    chk("err_ln", rsp_ln, 32'hc060c5a8);
    chk("err_err", 32'(rsp_err), 32'd1);
    chk("err_to", 32'(rsp_timeout), 32'd0);
    chk("err_grant", 32'(grant_id), 32'd2);
    req[2] = 1'b0;
    repeat (2) @(negedge clk);

    // Contention: all four from reset, each re-raised after its response.
    reset_n = 1'b0;
    req     = 4'hF;
    req_x   = {32'h3f4ccccd, 32'h3f19999a, 32'h3ecccccd, 32'h3e4ccccd};
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int n = 0; n < 6; n++) begin
      wait_rsp(100);
      exp_g = n % 4;
      oh    = 4'b0001 << exp_g;
      chk("cont_grant", 32'(grant_id), 32'(exp_g));
      chk("cont_valid", 32'(rsp_valid), 32'(oh));
      chk("cont_ln", rsp_ln, exp_ln[exp_g]);
      req[exp_g] = 1'b0;
      @(negedge clk);
      if (n < 4) req[exp_g] = 1'b1;
    end
    req = '0;
    repeat (2) @(negedge clk);

    // Watchdog: engine accepts start but never finishes.
    hang          = 1'b1;
    req_x[63:32]  = 32'h3f800000;
    req[1]        = 1'b1;
    wait_rsp(200);
    chk("to_valid", 32'(rsp_valid), 32'h2);
    chk("to_ln", rsp_ln, 32'd0);
    chk("to_err", 32'(rsp_err), 32'd1);
    chk("to_to", 32'(rsp_timeout), 32'd1);
    chk("to_cycles", 32'(rsp_cycles), 32'd64);
    chk("to_start", 32'(eng_start), 32'd0);
    chk("to_grant", 32'(grant_id), 32'd1);
    req[1] = 1'b0;
    repeat (2) @(negedge clk);
    req[3] = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      chk("to_no_restart", 32'(eng_start), 32'd0);
    end
    chk("to_held_idle", 32'(busy), 32'd0);
    hang = 1'b0;
    wait_rsp(100);
    chk("drain_valid", 32'(rsp_valid), 32'h8);
    chk("drain_ln", rsp_ln, 32'h3f1d222c);
    chk("drain_err", 32'(rsp_err), 32'd0);
    chk("drain_to", 32'(rsp_timeout), 32'd0);
    chk("drain_cycles", 32'(rsp_cycles), 32'd22);
    req[3] = 1'b0;
    repeat (2) @(negedge clk);

    // Reset in the middle of WAIT2.
    req[2] = 1'b1;
    repeat (8) @(negedge clk);
    chk("midrst_busy_before", 32'(busy), 32'd1);
    chk("midrst_eng_x_before", eng_x, 32'h3f19999a);
    reset_n = 1'b0;
    @(negedge clk);
    chk_reset_vals("midrst");
    reset_n     = 1'b1;
    req[2]      = 1'b0;
    req_x[31:0] = 32'h00000000;
    req[0]      = 1'b1;
    wait_rsp(100);
    chk("post_rst_valid", 32'(rsp_valid), 32'h1);
    chk("post_rst_ln", rsp_ln, 32'h00000000);
    chk("post_rst_err", 32'(rsp_err), 32'd0);
    chk("post_rst_grant", 32'(grant_id), 32'd0);
    req[0] = 1'b0;
    repeat (2) @(negedge clk);

    // Engine reports not-done while the arbiter is idle.
    force_busy   = 1'b1;
    req_x[63:32] = 32'h3ecccccd;
    req[1]       = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("engbusy_no_start", 32'(eng_start), 32'd0);
      chk("engbusy_idle", 32'(busy), 32'd0);
    end
    force_busy = 1'b0;
    wait_rsp(100);
    chk("engbusy_valid", 32'(rsp_valid), 32'h2);
    chk("engbusy_ln", rsp_ln, 32'h3eac88d1);
    chk("engbusy_err", 32'(rsp_err), 32'd0);
    chk("engbusy_cycles", 32'(rsp_cycles), 32'd22);
    chk("engbusy_grant", 32'(grant_id), 32'd1);
    req[1] = 1'b0;
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ln_engine_arbiter.md
# ln_engine_arbiter

Round-robin arbiter and sequencer that shares one `maclaurin_box` ln(1+x) engine (IEEE-754 single, start/status handshake) among `NREQ` requesters. Each requester posts a 32-bit operand and receives the 32-bit result, the engine error flag and a timeout flag. The block sits between the client units and the single engine instance, owns the engine's `start`, and guarantees the engine sees at most one operation at a time.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `TIMEOUT`, 4096: engine cycle budget per operation, 2..65535.
- `clk` in 1: clock.
- `reset_n` in 1: reset, synchronous, active-low.
- `req` in NREQ: per-requester request level.
- `req_x` in 32*NREQ: operands, requester i at bits [32i+31:32i].
- `rsp_valid` out NREQ: one-hot, one-cycle result strobe.
- `rsp_ln` out 32: result, valid with `rsp_valid`.
- `rsp_err` out 1: engine error bit (`status[0]`), or 1 on timeout.
- `rsp_timeout` out 1: operation aborted by watchdog.
- `rsp_cycles` out 16: cycles spent in WAIT1+WAIT2 for this operation, saturating at 0xFFFF.
- `eng_x` out 32: operand to engine.
- `eng_start` out 1: engine start.
- `eng_status` in 2: [1]=done/idle, [0]=error.
- `eng_ln` in 32: engine result.
- `busy` out 1: high in every state except IDLE.
- `grant_id` out 3: index of current or last grantee.

## Operation
- Requester rule: raise `req[i]` with `req_x` stable; hold both until `rsp_valid[i]`; drop `req[i]` the next cycle. Dropping `req` after grant does not cancel the operation; the response is still issued.
- Round-robin: the pointer `rr` resets to 0. In IDLE, grant the first asserted `req` scanning `rr`, `rr+1`, … mod `NREQ`. After each response, `rr` ← grantee+1 mod `NREQ`.
- FSM states: IDLE, START, WAIT1, WAIT2, RESP, GAP. All outputs are registered.
  - IDLE: if `eng_status[1]`=1 and `|req`, latch g→`grant_id`, `eng_x`←`req_x[g]`, clear the cycle counter, go to START. If done=0, stay.
  - START: `eng_start`←1, go to WAIT1.
  - WAIT1: count +1. When `eng_status[1]`=0, `eng_start`←0 and go to WAIT2.
  - WAIT2: count +1. When `eng_status[1]`=1: `rsp_ln`←`eng_ln`, `rsp_err`←`eng_status[0]`, `rsp_timeout`←0, `rsp_cycles`←count, `rsp_valid[g]`←1, go to RESP.
  - RESP: `rsp_valid`←0, update `rr`, go to GAP.
  - GAP: `req` is ignored, go to IDLE. This lets the grantee drop its request.
- Watchdog: the count is held in WAIT1/WAIT2. If count reaches `TIMEOUT` before completion, set `eng_start`←0, `rsp_ln`←0, `rsp_err`←1, `rsp_timeout`←1, `rsp_cycles`←`TIMEOUT`, `rsp_valid[g]`←1, then RESP. The next grant still waits for done=1 in IDLE, so a late engine finish is drained naturally and its result is discarded.
- `rsp_ln`, `rsp_err`, `rsp_timeout`, `rsp_cycles` and `grant_id` hold their values until the next response or grant.

## Timing
- Reset values: `rsp_valid`=0, `rsp_ln`=0, `rsp_err`=0, `rsp_timeout`=0, `rsp_cycles`=0, `eng_x`=0, `eng_start`=0, `busy`=0, `grant_id`=0, `rr`=0, state IDLE.
- Reset mid-operation: all of the above apply on the next edge. The engine is not reset by this block; the next grant waits for done=1.
- With IDLE, done=1 and `req[i]` sampled at edge 0:
  - `eng_x` is valid after edge 1.
  - `eng_start` is high after edge 2.
  - `eng_start` falls on the edge after done is sampled low.
  - `rsp_valid[i]` is high for exactly one cycle, beginning on the edge after done is sampled high in WAIT2.
- Minimum arbiter overhead per operation: 5 cycles plus engine time. Back-to-back grants are spaced by RESP+GAP.
- If `req` arrives simultaneously from several requesters, exactly one is granted per operation, in round-robin order. No requester waits more than `NREQ`-1 operations.
- If done never falls, WAIT1 times out and `eng_start` is then dropped.

## Test plan
- Single request: `req[0]`, x=0x3f800000, engine model latency 20 → `rsp_valid[0]` once, `rsp_ln`=0x3f488889, `rsp_err`=0, `rsp_cycles`=21±1, `eng_start` high until done falls.
- Error passthrough: `req[2]`, x=0xbf99999a → `rsp_ln`=0xc060c5a8, `rsp_err`=1, `rsp_timeout`=0.
- Contention: all 4 `req` high from reset, each re-raised after its response → grant order 0,1,2,3,0,1; each `rsp_valid` one-hot and matching its operand (0.2→0x3e3ab4e4, 0.4→0x3eac88d1, 0.6→0x3ef3471f, 0.8→0x3f1d222c).
- Timeout: `TIMEOUT`=64, engine never returns done → `rsp_valid[g]` at count 64 with `rsp_ln`=0, `rsp_err`=1, `rsp_timeout`=1. No new `eng_start` until the engine raises done.
- Reset mid-WAIT2 → all outputs return to reset values on the next edge. A new request then completes normally (x=0 → 0x00000000).
- Engine busy at idle: `req[1]` while done=0 for 10 cycles → no `eng_start` until done=1, then normal completion.
